custom_protocol_rx: RTL and testbench
=====================================

CUSTOM_PROTOCOL_RX -- requirements
Module: custom_protocol_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 4: bus width in bits; legal values are 2 to 32.
REQ-002 SHALL have parameter BEATS, default 4: data beats per frame; legal values are 1 to 16.
REQ-003 SHALL have parameter TIMEOUT, default 15: maximum idle strobe-less cycles inside a frame; legal values are 1 to 255.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port direction_pin, input, 1 bit: 1 = master to slave, 0 = slave to master.
REQ-007 SHALL have port strobe_pin, input, 1 bit: 1 = the selected bus carries a valid beat this cycle.
REQ-008 SHALL have port master_data_in, input, DATA_W bits: master bus.
REQ-009 SHALL have port slave_data_in, input, DATA_W bits: slave bus.
REQ-010 SHALL have port frame_data, output, DATA_W*BEATS bits: last good frame, with beat 0 in the LSBs.
REQ-011 SHALL have port frame_dir, output, 1 bit: direction of the last good frame.
REQ-012 SHALL have port frame_valid, output, 1 bit: one-cycle pulse when a frame passes its checksum.
REQ-013 SHALL have port frame_error, output, 1 bit: one-cycle pulse on checksum mismatch, direction change or timeout.
REQ-014 SHALL have port timeout_err, output, 1 bit: one-cycle pulse, asserted together with frame_error, when the frame ends by timeout.
REQ-015 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-016 SHALL have port err_count, output, 8 bits: saturating count of frame_error pulses.

Function
REQ-017 SHALL register bit 0 of both buses every cycle into prev_m and prev_s.
REQ-018 SHALL define sel_bus as master_data_in when direction_pin=1, else slave_data_in; prev_sel is the matching prev_m or prev_s.
REQ-019 SHALL implement a state machine with states IDLE, DATA and CHECK, registered and updated on clk.
REQ-020 IDLE: SHALL go to DATA when sel_bus[0] differs from prev_sel, latching direction_pin as dir_lat and clearing beat_cnt and the running XOR.
- The cycle that triggers the start is never a data beat.
- strobe_pin is ignored in IDLE.
REQ-021 DATA: on each cycle with strobe_pin=1, SHALL store sel_bus into slot beat_cnt, XOR it into the running checksum, and increment beat_cnt.
- After beat BEATS-1 is stored, the next state is CHECK.
REQ-022 CHECK: SHALL treat the next strobed word as the checksum and compare it with the XOR of all BEATS data words, then return to IDLE.
REQ-023 On checksum match, SHALL update frame_data and frame_dir and pulse frame_valid in the cycle after the checksum strobe.
REQ-024 On checksum mismatch, SHALL pulse frame_error in the cycle after the checksum strobe and leave frame_data and frame_dir unchanged.
REQ-025 In DATA or CHECK, SHALL abort to IDLE with a frame_error pulse if direction_pin differs from dir_lat; the abort takes priority over a strobe in the same cycle.
REQ-026 SHALL reset an idle counter on every strobe and on entry to DATA.
- If the counter reaches TIMEOUT with no strobe, the block SHALL return to IDLE and pulse frame_error and timeout_err together.
REQ-027 SHALL pulse at most one of frame_valid and frame_error in any cycle.
REQ-028 SHALL increment err_count on each frame_error pulse and hold it at 255 once reached.
REQ-029 SHALL re-arm start detection one cycle after returning to IDLE, so back-to-back frames are accepted.

Reset
REQ-030 While rst=1, SHALL hold:
- state=IDLE, beat_cnt=0, idle counter=0;
- prev_m=0, prev_s=0, running checksum=0;
- frame_data=0, frame_dir=0, err_count=0;
- frame_valid=0, frame_error=0, timeout_err=0, busy=0.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame with no pulse, and the frame count SHALL resume from beat 0 after release.

Verification (DATA_W=4, BEATS=4, TIMEOUT=15)
REQ-032 Master frame: direction=1, master bit0 toggles 0->1, strobed beats 1,2,3,4 followed by checksum 4 -> frame_valid pulses once, frame_data=0x4321, frame_dir=1.
REQ-033 Slave frame with bad checksum: direction=0, beats A,B,C,D, checksum 5 -> frame_error pulses once, err_count=1, frame_data holds its previous value.
REQ-034 Strobe gaps: 3 strobe-low cycles between each beat of the REQ-032 frame -> identical result, and busy stays high throughout.
REQ-035 Timeout: 2 beats, then strobe held low -> frame_error and timeout_err pulse together on the 15th idle cycle, after which busy=0.
REQ-036 Direction flip after beat 2 -> frame_error pulses the next cycle, the state returns to IDLE, and frame_valid never asserts.
REQ-037 Reset mid-frame after beat 3, then a full valid frame -> no pulse during reset, and the second frame gives frame_valid with the correct data.

Source files
------------

// File: rtl/custom_protocol_rx.sv
// Frame receiver: a bit-0 edge on the selected bus opens a frame of BEATS strobed
// words followed by one XOR checksum word; direction changes and idle gaps abort it.
module custom_protocol_rx #(
   parameter int DATA_W  = 4,
   parameter int BEATS   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    direction_pin,
   input  logic                    strobe_pin,
   input  logic [DATA_W-1:0]       master_data_in,
   input  logic [DATA_W-1:0]       slave_data_in,
   output logic [DATA_W*BEATS-1:0] frame_data,
   output logic                    frame_dir,
   output logic                    frame_valid,
   output logic                    frame_error,
   output logic                    timeout_err,
   output logic                    busy,
   output logic [7:0]              err_count
);

   localparam int         FRAME_W    = DATA_W * BEATS;
   localparam logic [4:0] LAST_BEAT  = 5'(BEATS - 1);
   localparam logic [7:0] IDLE_LIMIT = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;

   state_t              state_q, state_d;
   logic                prev_m_q, prev_m_d;
   logic                prev_s_q, prev_s_d;
   logic                dir_lat_q, dir_lat_d;
   logic [4:0]          beat_cnt_q, beat_cnt_d;
   logic [7:0]          idle_cnt_q, idle_cnt_d;
   logic [DATA_W-1:0]   xor_q, xor_d;
   logic [FRAME_W-1:0]  slots_q, slots_d;
   logic [FRAME_W-1:0]  frame_data_q, frame_data_d;
   logic                frame_dir_q, frame_dir_d;
   logic                frame_valid_q, frame_valid_d;
   logic                frame_error_q, frame_error_d;
   logic                timeout_err_q, timeout_err_d;
   logic [7:0]          err_count_q, err_count_d;

   logic [DATA_W-1:0]   sel_bus;
   logic                prev_sel;

   always_comb begin
      sel_bus       = direction_pin ? master_data_in : slave_data_in;
      prev_sel      = direction_pin ? prev_m_q : prev_s_q;

      state_d       = state_q;
      prev_m_d      = master_data_in[0];
      prev_s_d      = slave_data_in[0];
      dir_lat_d     = dir_lat_q;
      beat_cnt_d    = beat_cnt_q;
      idle_cnt_d    = idle_cnt_q;
      xor_d         = xor_q;
      slots_d       = slots_q;
      frame_data_d  = frame_data_q;
      frame_dir_d   = frame_dir_q;
      frame_valid_d = 1'b0;
      frame_error_d = 1'b0;
      timeout_err_d = 1'b0;

      case (state_q)
         IDLE: begin
            // The start cycle itself never carries a beat, strobed or not.
            if (sel_bus[0] != prev_sel) begin
               state_d    = DATA;
               dir_lat_d  = direction_pin;
               beat_cnt_d = 5'd0;
               idle_cnt_d = 8'd0;
               xor_d      = '0;
            end
         end
         DATA, CHECK: begin
            if (direction_pin != dir_lat_q) begin
               state_d       = IDLE;
               frame_error_d = 1'b1;
            end else if (strobe_pin) begin
               idle_cnt_d = 8'd0;
               if (state_q == DATA) begin
                  for (int i = 0; i < BEATS; i++) begin
                     if (beat_cnt_q == 5'(i)) slots_d[i*DATA_W +: DATA_W] = sel_bus;
                  end
                  xor_d      = xor_q ^ sel_bus;
                  beat_cnt_d = beat_cnt_q + 5'd1;
                  if (beat_cnt_q == LAST_BEAT) state_d = CHECK;
               end else begin
                  if (sel_bus == xor_q) begin
                     frame_valid_d = 1'b1;
                     frame_data_d  = slots_q;
                     frame_dir_d   = dir_lat_q;
                  end else begin
                     frame_error_d = 1'b1;
                  end
                  state_d = IDLE;
               end
            end else if (idle_cnt_q == IDLE_LIMIT) begin
               state_d       = IDLE;
               frame_error_d = 1'b1;
               timeout_err_d = 1'b1;
            end else begin
               idle_cnt_d = idle_cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      err_count_d = (frame_error_d && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         prev_m_q      <= 1'b0;
         prev_s_q      <= 1'b0;
         dir_lat_q     <= 1'b0;
         beat_cnt_q    <= 5'd0;
         idle_cnt_q    <= 8'd0;
         xor_q         <= '0;
         frame_data_q  <= '0;
         frame_dir_q   <= 1'b0;
         frame_valid_q <= 1'b0;
         frame_error_q <= 1'b0;
         timeout_err_q <= 1'b0;
         err_count_q   <= 8'd0;
      end else begin
         state_q       <= state_d;
         prev_m_q      <= prev_m_d;
         prev_s_q      <= prev_s_d;
         dir_lat_q     <= dir_lat_d;
         beat_cnt_q    <= beat_cnt_d;
         idle_cnt_q    <= idle_cnt_d;
         xor_q         <= xor_d;
         frame_data_q  <= frame_data_d;
         frame_dir_q   <= frame_dir_d;
         frame_valid_q <= frame_valid_d;
         frame_error_q <= frame_error_d;
         timeout_err_q <= timeout_err_d;
         err_count_q   <= err_count_d;
      end
   end

   // Slot storage is fully rewritten before any frame can complete, so it needs no reset.
   always_ff @(posedge clk) begin
      slots_q <= slots_d;
   end

   assign frame_data  = frame_data_q;
   assign frame_dir   = frame_dir_q;
   assign frame_valid = frame_valid_q;
   assign frame_error = frame_error_q;
   assign timeout_err = timeout_err_q;
   assign busy        = (state_q != IDLE);
   assign err_count   = err_count_q;

endmodule

// File: tb/tb_custom_protocol_rx.sv
// Bench for custom_protocol_rx: directed frames plus random back-to-back traffic,
// scored against a queue-based frame model.
module tb_custom_protocol_rx;
   localparam int DW = 4;
   localparam int NB = 4;
   localparam int TO = 15;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               direction_pin = 1'b0;
   logic               strobe_pin = 1'b0;
   logic [DW-1:0]      master_data_in = '0;
   logic [DW-1:0]      slave_data_in = '0;
   logic [DW*NB-1:0]   frame_data;
   logic               frame_dir, frame_valid, frame_error, timeout_err, busy;
   logic [7:0]         err_count;

   int n_checks = 0;
   int n_pass   = 0;

   custom_protocol_rx #(.DATA_W(DW), .BEATS(NB), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .direction_pin(direction_pin), .strobe_pin(strobe_pin),
      .master_data_in(master_data_in), .slave_data_in(slave_data_in),
      .frame_data(frame_data), .frame_dir(frame_dir), .frame_valid(frame_valid),
      .frame_error(frame_error), .timeout_err(timeout_err), .busy(busy),
      .err_count(err_count)
   );

   always #5 clk = ~clk;

   // Reference model: a frame is a list of strobed words; it ends when the list holds
   // NB data words plus a checksum, on a direction change, or after TO silent cycles.
   logic           m_active = 1'b0;
   logic           m_dir = 1'b0;
   logic [DW-1:0]  m_q[$];
   int             m_gap = 0;
   logic           m_prev_m = 1'b0, m_prev_s = 1'b0;
   logic [DW-1:0]  m_sel, m_x;
   logic           m_psel;
   logic [DW*NB-1:0] e_data = '0;
   logic           e_dir = 1'b0, e_valid = 1'b0, e_error = 1'b0, e_tmo = 1'b0;
   logic [7:0]     e_cnt = 8'd0;
   int             e_nvalid = 0, e_nerr = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active = 1'b0; m_q.delete(); m_gap = 0; m_prev_m = 1'b0; m_prev_s = 1'b0;
         e_data = '0; e_dir = 1'b0; e_valid = 1'b0; e_error = 1'b0; e_tmo = 1'b0; e_cnt = 8'd0;
      end else begin
         m_sel  = direction_pin ? master_data_in : slave_data_in;
         m_psel = direction_pin ? m_prev_m : m_prev_s;
         e_valid = 1'b0; e_error = 1'b0; e_tmo = 1'b0;
         if (!m_active) begin
            if (m_sel[0] !== m_psel) begin
               m_active = 1'b1; m_dir = direction_pin; m_q.delete(); m_gap = 0;
            end
         end else if (direction_pin !== m_dir) begin
            m_active = 1'b0; e_error = 1'b1;
         end else if (strobe_pin) begin
            m_gap = 0;
            m_q.push_back(m_sel);
            if (m_q.size() == NB + 1) begin
               m_x = '0;
               for (int i = 0; i < NB; i++) m_x = m_x ^ m_q[i];
               if (m_x === m_q[NB]) begin
                  e_valid = 1'b1; e_dir = m_dir;
                  for (int i = 0; i < NB; i++) e_data[i*DW +: DW] = m_q[i];
               end else begin
                  e_error = 1'b1;
               end
               m_active = 1'b0;
            end
         end else begin
            m_gap++;
            if (m_gap == TO) begin
               e_error = 1'b1; e_tmo = 1'b1; m_active = 1'b0;
            end
         end
         if (e_error && e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
         if (e_valid) e_nvalid++;
         if (e_error) e_nerr++;
         m_prev_m = master_data_in[0];
         m_prev_s = slave_data_in[0];
      end
   end

   int vec_bad = 0, n_valid = 0, n_err = 0, n_both = 0;
   always begin
      @(posedge clk);
      #2;
      if (!rst) begin
         if ({frame_data, frame_dir, frame_valid, frame_error, timeout_err, busy, err_count} !==
             {e_data, e_dir, e_valid, e_error, e_tmo, m_active, e_cnt}) vec_bad++;
         if (frame_valid) n_valid++;
         if (frame_error) n_err++;
         if (frame_valid && frame_error) n_both++;
      end
   end

   task automatic cyc(input logic d, input logic st, input logic [DW-1:0] v);
      direction_pin = d;
      strobe_pin    = st;
      if (d) master_data_in = v;
      else slave_data_in = v;
      @(negedge clk);
   endtask

   function automatic logic [DW-1:0] cur(input logic d);
      return d ? master_data_in : slave_data_in;
   endfunction

   task automatic start(input logic d);
      logic [DW-1:0] v;
      v    = cur(d);
      v[0] = ~v[0];
      cyc(d, 1'b0, v);
   endtask

   task automatic send_frame(input logic d, input logic [(NB+1)*DW-1:0] w, input int gap);
      start(d);
      for (int i = 0; i <= NB; i++) begin
         repeat (gap) cyc(d, 1'b0, cur(d));
         cyc(d, 1'b1, w[i*DW +: DW]);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if (frame_data !== 16'h0 || frame_dir !== 1'b0) $display("FAIL reset_frame got=%h/%b want=0/0", frame_data, frame_dir);
      else n_pass++;
      n_checks++;
      if ({frame_valid, frame_error, timeout_err, busy} !== 4'b0) $display("FAIL reset_flags got=%b want=0000", {frame_valid, frame_error, timeout_err, busy});
      else n_pass++;
      n_checks++;
      if (err_count !== 8'd0) $display("FAIL reset_errcnt got=%0d want=0", err_count);
      else n_pass++;
      rst = 1'b0;
      repeat (2) cyc(1'b1, 1'b0, 4'h0);
      n_checks++;
      if (busy !== 1'b0) $display("FAIL idle_busy got=%b want=0", busy);
      else n_pass++;
   endtask

   task automatic test_master_frame();
      int v0, e0;
      v0 = n_valid; e0 = n_err;
      send_frame(1'b1, 20'h44321, 0);
      n_checks++;
      if (frame_valid !== 1'b1) $display("FAIL master_valid got=%b want=1", frame_valid);
      else n_pass++;
      n_checks++;
      if (frame_data !== 16'h4321 || frame_dir !== 1'b1) $display("FAIL master_data got=%h/%b want=4321/1", frame_data, frame_dir);
      else n_pass++;
      repeat (2) cyc(1'b1, 1'b0, cur(1'b1));
      n_checks++;
      if (n_valid - v0 !== 1 || n_err - e0 !== 0) $display("FAIL master_pulses got=%0d/%0d want=1/0", n_valid - v0, n_err - e0);
      else n_pass++;
   endtask

   task automatic test_slave_bad_checksum();
      int v0, e0;
      v0 = n_valid; e0 = n_err;
      send_frame(1'b0, 20'h5DCBA, 0);
      n_checks++;
      if (frame_error !== 1'b1 || timeout_err !== 1'b0) $display("FAIL slave_err got=%b%b want=10", frame_error, timeout_err);
      else n_pass++;
      repeat (2) cyc(1'b0, 1'b0, cur(1'b0));
      n_checks++;
      if (n_err - e0 !== 1 || n_valid - v0 !== 0) $display("FAIL slave_pulses got=%0d/%0d want=1/0", n_err - e0, n_valid - v0);
      else n_pass++;
      n_checks++;
      if (err_count !== 8'd1) $display("FAIL slave_errcnt got=%0d want=1", err_count);
      else n_pass++;
      n_checks++;
      if (frame_data !== 16'h4321 || frame_dir !== 1'b1) $display("FAIL slave_hold got=%h/%b want=4321/1", frame_data, frame_dir);
      else n_pass++;
   endtask

   task automatic test_strobe_gaps();
      int v0, blow;
      logic [(NB+1)*DW-1:0] w;
      v0 = n_valid; blow = 0; w = 20'h44321;
      start(1'b1);
      for (int i = 0; i <= NB; i++) begin
         if (i > 0) begin
            repeat (3) begin
               cyc(1'b1, 1'b0, cur(1'b1));
               if (busy !== 1'b1) blow++;
            end
         end
         cyc(1'b1, 1'b1, w[i*DW +: DW]);
         if (i < NB && busy !== 1'b1) blow++;
      end
      n_checks++;
      if (frame_valid !== 1'b1 || frame_data !== 16'h4321 || frame_dir !== 1'b1) $display("FAIL gaps_frame got=%b/%h/%b want=1/4321/1", frame_valid, frame_data, frame_dir);
      else n_pass++;
      n_checks++;
      if (blow !== 0) $display("FAIL gaps_busy got=%0d low cycles want=0", blow);
      else n_pass++;
      repeat (2) cyc(1'b1, 1'b0, cur(1'b1));
      n_checks++;
      if (n_valid - v0 !== 1) $display("FAIL gaps_pulses got=%0d want=1", n_valid - v0);
      else n_pass++;
   endtask

   task automatic test_timeout();
      int early;
      early = 0;
      start(1'b1);
      cyc(1'b1, 1'b1, 4'h9);
      cyc(1'b1, 1'b1, 4'h6);
      for (int i = 1; i <= TO; i++) begin
         cyc(1'b1, 1'b0, cur(1'b1));
         if (i < TO && (frame_error !== 1'b0 || busy !== 1'b1)) early++;
      end
      n_checks++;
      if (early !== 0) $display("FAIL timeout_early got=%0d want=0", early);
      else n_pass++;
      n_checks++;
      if (frame_error !== 1'b1 || timeout_err !== 1'b1) $display("FAIL timeout_pulse got=%b%b want=11", frame_error, timeout_err);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b0 || err_count !== 8'd2) $display("FAIL timeout_after got=%b/%0d want=0/2", busy, err_count);
      else n_pass++;
      cyc(1'b1, 1'b0, cur(1'b1));
   endtask

   task automatic test_dir_flip();
      int v0;
      v0 = n_valid;
      start(1'b1);
      cyc(1'b1, 1'b1, 4'h1);
      cyc(1'b1, 1'b1, 4'h2);
      cyc(1'b0, 1'b1, cur(1'b0));
      n_checks++;
      if (frame_error !== 1'b1 || timeout_err !== 1'b0 || busy !== 1'b0) $display("FAIL flip_abort got=%b%b%b want=100", frame_error, timeout_err, busy);
      else n_pass++;
      repeat (3) cyc(1'b0, 1'b0, cur(1'b0));
      n_checks++;
      if (n_valid - v0 !== 0 || err_count !== 8'd3) $display("FAIL flip_after got=%0d/%0d want=0/3", n_valid - v0, err_count);
      else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      int v0, pulses;
      pulses = 0;
      start(1'b1);
      cyc(1'b1, 1'b1, 4'h1);
      cyc(1'b1, 1'b1, 4'h2);
      cyc(1'b1, 1'b1, 4'h3);
      rst = 1'b1;
      repeat (3) begin
         cyc(1'b1, 1'b0, 4'h0);
         if (frame_valid || frame_error || timeout_err) pulses++;
      end
      n_checks++;
      if (pulses !== 0) $display("FAIL rstmid_pulses got=%0d want=0", pulses);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b0 || err_count !== 8'd0 || frame_data !== 16'h0) $display("FAIL rstmid_state got=%b/%0d/%h want=0/0/0000", busy, err_count, frame_data);
      else n_pass++;
      rst = 1'b0;
      v0 = n_valid;
      send_frame(1'b1, 20'hC8765, 0);
      n_checks++;
      if (frame_valid !== 1'b1 || frame_data !== 16'h8765 || frame_dir !== 1'b1) $display("FAIL rstmid_frame got=%b/%h/%b want=1/8765/1", frame_valid, frame_data, frame_dir);
      else n_pass++;
      repeat (2) cyc(1'b1, 1'b0, cur(1'b1));
      n_checks++;
      if (n_valid - v0 !== 1) $display("FAIL rstmid_count got=%0d want=1", n_valid - v0);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic                 d;
      logic [(NB+1)*DW-1:0] w;
      logic [DW-1:0]        x;
      int                   gap, mode;
      for (int f = 0; f < 150; f++) begin
         d = 1'($urandom_range(0, 1));
         x = '0;
         for (int i = 0; i < NB; i++) begin
            w[i*DW +: DW] = DW'($urandom);
            x = x ^ w[i*DW +: DW];
         end
         w[NB*DW +: DW] = ($urandom_range(0, 3) != 0) ? x : DW'($urandom);
         gap  = $urandom_range(0, 2);
         mode = $urandom_range(0, 9);
         start(d);
         for (int i = 0; i <= NB; i++) begin
            if (mode == 0 && i == 2) begin
               repeat (TO + 1) cyc(d, 1'b0, cur(d));
               break;
            end
            if (mode == 1 && i == 2) begin
               cyc(~d, 1'b1, cur(~d));
               break;
            end
            repeat (gap) cyc(d, 1'b0, cur(d));
            cyc(d, 1'b1, w[i*DW +: DW]);
         end
      end
      repeat (2) cyc(direction_pin, 1'b0, cur(direction_pin));
      n_checks++;
      if (vec_bad !== 0) $display("FAIL model_vectors got=%0d differing cycles want=0", vec_bad);
      else n_pass++;
      n_checks++;
      if (n_valid !== e_nvalid || n_err !== e_nerr) $display("FAIL model_counts got=%0d/%0d want=%0d/%0d", n_valid, n_err, e_nvalid, e_nerr);
      else n_pass++;
      n_checks++;
      if (n_both !== 0) $display("FAIL exclusive_pulses got=%0d want=0", n_both);
      else n_pass++;
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 260; k++) send_frame(1'b1, 20'h10000, 0);
      repeat (2) cyc(1'b1, 1'b0, cur(1'b1));
      n_checks++;
      if (err_count !== 8'hFF) $display("FAIL errcnt_saturate got=%0d want=255", err_count);
      else n_pass++;
      n_checks++;
      if (vec_bad !== 0) $display("FAIL saturate_vectors got=%0d want=0", vec_bad);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_master_frame();
      test_slave_bad_checksum();
      test_strobe_gaps();
      test_timeout();
      test_dir_flip();
      test_reset_mid_frame();
      test_back_to_back();
      test_saturation();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
